// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset/chip-enable levels, word widths, NOP encoding
// and the fetch-stage FSM state encodings.
package cpu_defs_pkg;

    localparam logic        RstEnable     = 1'b1;
    localparam logic        ChipEnable    = 1'b1;
    localparam logic        ChipDisable   = 1'b0;
    localparam int          InstAddrWidth = 32;
    localparam int          InstDataWidth = 32;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    // MIPS sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NopInst       = 32'h0000_0000;
    localparam int          PcStep        = 4;

    typedef enum logic {
        IF_BOOT = 1'b0,
        IF_RUN  = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. bubble beats hold, hold beats load; when nothing
// is asserted the register keeps its contents.
module if_id_reg
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = InstAddrWidth,
    parameter int INST_W = InstDataWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              hold,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [INST_W-1:0] inst_in,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst,
    output logic              valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc    <= ADDR_W'(ZeroWord);
            inst  <= INST_W'(NopInst);
            valid <= 1'b0;
        end else if (bubble) begin
            pc    <= ADDR_W'(ZeroWord);
            inst  <= INST_W'(NopInst);
            valid <= 1'b0;
        end else if (load && !hold) begin
            pc    <= pc_in;
            inst  <= inst_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux and BOOT/RUN FSM.
// Define IF_DELAY_SLOT_EN for MIPS delay-slot capture on taken branches.
module if_stage
    import cpu_defs_pkg::*;
#(
    parameter int                ADDR_W   = InstAddrWidth,
    parameter int                INST_W   = InstDataWidth,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic [INST_W-1:0] inst_from_rom,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

    if_state_t         state;
    if_state_t         state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              id_load;
    logic              id_hold;
    logic              id_bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state <= IF_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IF_BOOT: state_next = IF_RUN;
            IF_RUN:  state_next = IF_RUN;
            default: state_next = IF_BOOT;
        endcase
    end

    always_comb begin
        rom_ce = (state == IF_RUN) ? ChipEnable : ChipDisable;
    end

    // Flush wins over stall, stall over branch; BOOT only honours a flush PC load
    always_comb begin
        pc_next   = pc;
        id_load   = 1'b0;
        id_hold   = 1'b0;
        id_bubble = 1'b0;
        if (state == IF_BOOT) begin
            id_bubble = 1'b1;
            if (flush_i) begin
                pc_next = flush_pc_i & AlignMask;
            end
        end else if (flush_i) begin
            pc_next   = flush_pc_i & AlignMask;
            id_bubble = 1'b1;
        end else if (stall_i) begin
            id_hold = 1'b1;
        end else if (branch_i) begin
            pc_next = branch_target_i & AlignMask;
`ifdef IF_DELAY_SLOT_EN
            id_load = 1'b1;
`else
            id_bubble = 1'b1;
`endif
        end else begin
            pc_next = pc + ADDR_W'(PcStep);
            id_load = 1'b1;
        end
    end

    assign rom_addr = pc;

    if_id_reg #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (id_load),
        .hold   (id_hold),
        .bubble (id_bubble),
        .pc_in  (pc),
        .inst_in(inst_from_rom),
        .pc     (id_pc_o),
        .inst   (id_inst_o),
        .valid  (id_valid_o)
    );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a PC-level reference model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] inst_from_rom;
    logic [31:0] rom_addr;
    logic        rom_ce;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    logic [31:0] rom_mem [0:63];

    logic [31:0] m_pc;
    logic        m_run;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    assign inst_from_rom = rom_mem[rom_addr[7:2]] ^ rom_addr;

    if_stage #(
        .ADDR_W  (32),
        .INST_W  (32),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .inst_from_rom  (inst_from_rom),
        .rom_addr       (rom_addr),
        .rom_ce         (rom_ce),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o),
        .id_valid_o     (id_valid_o)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return rom_mem[a[7:2]] ^ a;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_run = 1'b0;
        m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
    endtask

    // One clock of the fetch stage, written directly from the priority rules
    task automatic model_edge();
        if (!m_run) begin
            if (flush_i) m_pc = flush_pc_i & ~32'h3;
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
            m_run = 1'b1;
        end else if (flush_i) begin
            m_pc = flush_pc_i & ~32'h3;
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
        end else if (stall_i) begin
            m_pc = m_pc;
        end else if (branch_i) begin
`ifdef IF_DELAY_SLOT_EN
            m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_id_valid = 1'b1;
`else
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
`endif
            m_pc = branch_target_i & ~32'h3;
        end else begin
            m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_id_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] bt,
                        input logic f, input logic [31:0] fp);
        stall_i = s; branch_i = b; branch_target_i = bt; flush_i = f; flush_pc_i = fp;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        stall_i = 1'b0; branch_i = 1'b0; flush_i = 1'b0;
        branch_target_i = 32'h0; flush_pc_i = 32'h0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (rom_addr !== RESET_PC) begin n_fails++; $display("[TB] FAIL reset_rom_addr: got %h expected %h", rom_addr, RESET_PC); end
        n_checks++; if (rom_ce !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rom_ce: got %b expected 0", rom_ce); end
        n_checks++; if (id_pc_o !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_id_pc: got %h expected 0", id_pc_o); end
        n_checks++; if (id_inst_o !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_id_inst: got %h expected 0", id_inst_o); end
        n_checks++; if (id_valid_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_id_valid: got %b expected 0", id_valid_o); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (rom_ce !== 1'b1) begin n_fails++; $display("[TB] FAIL boot_rom_ce: got %b expected 1", rom_ce); end
        n_checks++; if (rom_addr !== RESET_PC) begin n_fails++; $display("[TB] FAIL boot_rom_addr: got %h expected %h", rom_addr, RESET_PC); end
        n_checks++; if (id_valid_o !== 1'b0) begin n_fails++; $display("[TB] FAIL boot_id_valid: got %b expected 0", id_valid_o); end
    endtask

    task automatic test_sequential();
        reset_dut();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            n_checks++; if (rom_addr !== RESET_PC + 32'(4 * (i + 1))) begin n_fails++; $display("[TB] FAIL seq_rom_addr[%0d]: got %h expected %h", i, rom_addr, RESET_PC + 32'(4 * (i + 1))); end
            n_checks++; if (id_pc_o !== RESET_PC + 32'(4 * i)) begin n_fails++; $display("[TB] FAIL seq_id_pc[%0d]: got %h expected %h", i, id_pc_o, RESET_PC + 32'(4 * i)); end
            n_checks++; if (id_inst_o !== rom_word(RESET_PC + 32'(4 * i))) begin n_fails++; $display("[TB] FAIL seq_id_inst[%0d]: got %h expected %h", i, id_inst_o, rom_word(RESET_PC + 32'(4 * i))); end
            n_checks++; if (id_valid_o !== 1'b1) begin n_fails++; $display("[TB] FAIL seq_id_valid[%0d]: got %b expected 1", i, id_valid_o); end
        end
    endtask

    task automatic test_stall();
        reset_dut();
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
            n_checks++; if (rom_addr !== 32'h8) begin n_fails++; $display("[TB] FAIL stall_rom_addr[%0d]: got %h expected 00000008", i, rom_addr); end
            n_checks++; if (id_pc_o !== 32'h4) begin n_fails++; $display("[TB] FAIL stall_id_pc[%0d]: got %h expected 00000004", i, id_pc_o); end
            n_checks++; if (id_inst_o !== rom_word(32'h4)) begin n_fails++; $display("[TB] FAIL stall_id_inst[%0d]: got %h expected %h", i, id_inst_o, rom_word(32'h4)); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            n_checks++; if (id_pc_o !== 32'(8 + 4 * i)) begin n_fails++; $display("[TB] FAIL resume_id_pc[%0d]: got %h expected %h", i, id_pc_o, 32'(8 + 4 * i)); end
            n_checks++; if (id_inst_o !== rom_word(32'(8 + 4 * i))) begin n_fails++; $display("[TB] FAIL resume_id_inst[%0d]: got %h expected %h", i, id_inst_o, rom_word(32'(8 + 4 * i))); end
        end
    endtask

    task automatic test_branch();
        reset_dut();
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        n_checks++; if (rom_addr !== 32'h40) begin n_fails++; $display("[TB] FAIL branch_rom_addr: got %h expected 00000040", rom_addr); end
`ifdef IF_DELAY_SLOT_EN
        n_checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h10) begin n_fails++; $display("[TB] FAIL branch_delay_slot: got valid %b pc %h expected valid 1 pc 00000010", id_valid_o, id_pc_o); end
`else
        n_checks++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin n_fails++; $display("[TB] FAIL branch_bubble: got valid %b inst %h expected valid 0 inst 0", id_valid_o, id_inst_o); end
`endif
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (id_pc_o !== 32'h40 || id_valid_o !== 1'b1) begin n_fails++; $display("[TB] FAIL branch_target_fetch: got pc %h valid %b expected pc 00000040 valid 1", id_pc_o, id_valid_o); end
    endtask

    task automatic test_flush_priority();
        reset_dut();
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h180);
        n_checks++; if (rom_addr !== 32'h180) begin n_fails++; $display("[TB] FAIL flush_rom_addr: got %h expected 00000180", rom_addr); end
        n_checks++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0) begin n_fails++; $display("[TB] FAIL flush_bubble: got valid %b inst %h expected valid 0 inst 0", id_valid_o, id_inst_o); end
        reset_dut();
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h103);
        n_checks++; if (rom_addr !== 32'h100 || rom_ce !== 1'b1 || id_valid_o !== 1'b0) begin n_fails++; $display("[TB] FAIL boot_flush: got addr %h ce %b valid %b expected addr 00000100 ce 1 valid 0", rom_addr, rom_ce, id_valid_o); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (id_pc_o !== 32'h100 || rom_addr !== 32'h104) begin n_fails++; $display("[TB] FAIL boot_flush_fetch: got id_pc %h addr %h expected 00000100 00000104", id_pc_o, rom_addr); end
    endtask

    task automatic test_wrap_align();
        reset_dut();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        n_checks++; if (rom_addr !== 32'hFFFF_FFFC) begin n_fails++; $display("[TB] FAIL wrap_rom_addr0: got %h expected fffffffc", rom_addr); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (rom_addr !== 32'h0) begin n_fails++; $display("[TB] FAIL wrap_rom_addr1: got %h expected 00000000", rom_addr); end
        n_checks++; if (id_pc_o !== 32'hFFFF_FFFC || id_inst_o !== rom_word(32'hFFFF_FFFC)) begin n_fails++; $display("[TB] FAIL wrap_id: got pc %h inst %h expected fffffffc %h", id_pc_o, id_inst_o, rom_word(32'hFFFF_FFFC)); end
        step(1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
        n_checks++; if (rom_addr !== 32'h40) begin n_fails++; $display("[TB] FAIL align_rom_addr: got %h expected 00000040", rom_addr); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (rom_addr !== RESET_PC || rom_ce !== 1'b0) begin n_fails++; $display("[TB] FAIL async_rst_pc: got addr %h ce %b expected %h 0", rom_addr, rom_ce, RESET_PC); end
        n_checks++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || id_pc_o !== 32'h0) begin n_fails++; $display("[TB] FAIL async_rst_id: got valid %b inst %h pc %h expected all 0", id_valid_o, id_inst_o, id_pc_o); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (rom_addr !== RESET_PC || rom_ce !== 1'b1 || id_valid_o !== 1'b0) begin n_fails++; $display("[TB] FAIL async_rst_boot: got addr %h ce %b valid %b expected %h 1 0", rom_addr, rom_ce, id_valid_o, RESET_PC); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++; if (rom_addr !== RESET_PC + 32'd4 || id_pc_o !== RESET_PC || id_valid_o !== 1'b1) begin n_fails++; $display("[TB] FAIL async_rst_fetch: got addr %h id_pc %h valid %b", rom_addr, id_pc_o, id_valid_o); end
    endtask

    task automatic test_random();
        logic        s, b, f;
        logic [31:0] bt, fp;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) reset_dut();
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 5) == 0);
            f  = ($urandom_range(0, 15) == 0);
            bt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            fp = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(s, b, bt, f, fp);
            n_checks++; if (rom_addr !== m_pc) begin n_fails++; $display("[TB] FAIL rand_rom_addr[%0d]: got %h expected %h", i, rom_addr, m_pc); end
            n_checks++; if (rom_ce !== m_run) begin n_fails++; $display("[TB] FAIL rand_rom_ce[%0d]: got %b expected %b", i, rom_ce, m_run); end
            n_checks++; if (id_valid_o !== m_id_valid) begin n_fails++; $display("[TB] FAIL rand_id_valid[%0d]: got %b expected %b", i, id_valid_o, m_id_valid); end
            n_checks++; if (id_inst_o !== m_id_inst) begin n_fails++; $display("[TB] FAIL rand_id_inst[%0d]: got %h expected %h", i, id_inst_o, m_id_inst); end
            if (m_id_valid) begin
                n_checks++; if (id_pc_o !== m_id_pc) begin n_fails++; $display("[TB] FAIL rand_id_pc[%0d]: got %h expected %h", i, id_pc_o, m_id_pc); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush_priority();
        test_wrap_align();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
